// File: rtl/dff_checker.sv
// Observing-side checker for a D flip-flop interface: models expected q over LATENCY clocks,
// counts compared samples and mismatches, captures the first failure. Option: DFF_CHECKER_HALT_ON_ERR_EN.
module dff_checker #(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] d_obs,
  input  logic [WIDTH-1:0] q_obs,
  input  logic [WIDTH-1:0] qbar_obs,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] sample_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_q,
  output logic             busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
`ifdef DFF_CHECKER_HALT_ON_ERR_EN
  localparam logic [1:0] S_HALT  = 2'd3;
`endif
  localparam logic [3:0] LAT_C   = 4'(LATENCY);

  logic [1:0]       r_state;
  logic [3:0]       r_fill;
  logic [WIDTH-1:0] r_pipe [LATENCY];
  logic             r_err_pulse;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_smp_cnt;
  logic             r_fe_vld;
  logic [WIDTH-1:0] r_fe_exp;
  logic [WIDTH-1:0] r_fe_q;

  logic [WIDTH-1:0] w_exp;
  logic             w_mismatch;
  logic             w_cmp;
  logic             w_shift;
  logic [3:0]       w_fill_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_exp      = r_pipe[LATENCY-1];
  assign w_mismatch = (q_obs != w_exp) || (qbar_obs != ~q_obs);
  assign w_cmp      = (r_state == S_CHECK) && en && !clear;
  assign w_fill_nxt = r_fill + 4'd1;
`ifdef DFF_CHECKER_HALT_ON_ERR_EN
  assign w_shift    = en && (r_state != S_HALT);
`else
  assign w_shift    = en;
`endif

  // Expected-q pipeline: stage k holds d_obs sampled k+1 clocks ago
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else if (w_shift) begin
      r_pipe[0] <= d_obs;
      for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // The enabling edge in IDLE already captures the first pipeline entry, so with
  // LATENCY=1 the pipeline is full immediately and checking starts on the next clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_fill  <= '0;
    end else if (clear) begin
      r_state <= en ? S_FILL : S_IDLE;
      r_fill  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_fill  <= 4'd1;
            r_state <= (LAT_C == 4'd1) ? S_CHECK : S_FILL;
          end
        end
        S_FILL: begin
          if (!en) begin
            r_state <= S_IDLE;
            r_fill  <= '0;
          end else begin
            r_fill <= w_fill_nxt;
            if (w_fill_nxt >= LAT_C) r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!en) begin
            r_state <= S_IDLE;
            r_fill  <= '0;
          end
`ifdef DFF_CHECKER_HALT_ON_ERR_EN
          else if (w_mismatch) begin
            r_state <= S_HALT;
          end
`endif
        end
`ifdef DFF_CHECKER_HALT_ON_ERR_EN
        S_HALT: r_state <= S_HALT;
`endif
        default: begin
          r_state <= S_IDLE;
          r_fill  <= '0;
        end
      endcase
    end
  end

  // Counters and first-failure capture; only advance on compared cycles
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
      r_smp_cnt   <= '0;
      r_fe_vld    <= 1'b0;
      r_fe_exp    <= '0;
      r_fe_q      <= '0;
    end else begin
      r_err_pulse <= w_cmp && w_mismatch;
      if (w_cmp) begin
        r_smp_cnt <= sat_inc(r_smp_cnt);
        if (w_mismatch) begin
          r_err_cnt <= sat_inc(r_err_cnt);
          if (!r_fe_vld) begin
            r_fe_vld <= 1'b1;
            r_fe_exp <= w_exp;
            r_fe_q   <= q_obs;
          end
        end
      end
    end
  end

  assign err_pulse       = r_err_pulse;
  assign err_count       = r_err_cnt;
  assign sample_count    = r_smp_cnt;
  assign first_err_valid = r_fe_vld;
  assign first_err_exp   = r_fe_exp;
  assign first_err_q     = r_fe_q;
  assign busy            = (r_state == S_FILL) || (r_state == S_CHECK);

endmodule

// File: tb/tb_dff_checker.sv
// Directed bench for dff_checker: an ideal 1-clock DFF against LATENCY=1, and a
// 2-clock delay against LATENCY=3 with 4-bit saturating counters.
module tb_dff_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  // Instance A: WIDTH=4, LATENCY=1, CNT_W=16, observing an ideal DFF
  logic        en_a, clr_a, inj_a;
  logic [3:0]  d_a, qflip_a;
  logic [3:0]  q_ff_a = 4'h0;
  logic [3:0]  q_obs_a, qbar_obs_a;
  logic        err_pulse_a, fe_vld_a, busy_a;
  logic [15:0] err_cnt_a, smp_cnt_a;
  logic [3:0]  fe_exp_a, fe_q_a;

  always @(posedge clk) q_ff_a <= d_a;
  assign q_obs_a    = q_ff_a ^ qflip_a;
  assign qbar_obs_a = inj_a ? q_obs_a : ~q_obs_a;

  dff_checker #(.WIDTH(4), .LATENCY(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .en(en_a), .clear(clr_a),
    .d_obs(d_a), .q_obs(q_obs_a), .qbar_obs(qbar_obs_a),
    .err_pulse(err_pulse_a), .err_count(err_cnt_a), .sample_count(smp_cnt_a),
    .first_err_valid(fe_vld_a), .first_err_exp(fe_exp_a), .first_err_q(fe_q_a),
    .busy(busy_a)
  );

  // Instance B: WIDTH=4, LATENCY=3, CNT_W=4, observing a 2-clock delay
  logic       en_b, clr_b;
  logic [3:0] d_b;
  logic [3:0] dly1_b = 4'h0;
  logic [3:0] dly2_b = 4'h0;
  logic [3:0] qbar_obs_b;
  logic       err_pulse_b, fe_vld_b, busy_b;
  logic [3:0] err_cnt_b, smp_cnt_b;
  logic [3:0] fe_exp_b, fe_q_b;

  always @(posedge clk) begin
    dly1_b <= d_b;
    dly2_b <= dly1_b;
  end
  assign qbar_obs_b = ~dly2_b;

  dff_checker #(.WIDTH(4), .LATENCY(3), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .clear(clr_b),
    .d_obs(d_b), .q_obs(dly2_b), .qbar_obs(qbar_obs_b),
    .err_pulse(err_pulse_b), .err_count(err_cnt_b), .sample_count(smp_cnt_b),
    .first_err_valid(fe_vld_b), .first_err_exp(fe_exp_b), .first_err_q(fe_q_b),
    .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] dv [5] = '{4'h0, 4'h5, 4'hA, 4'hF, 4'h3};

  initial begin
    rst = 1'b1;
    en_a = 1'b0; clr_a = 1'b0; inj_a = 1'b0; d_a = 4'h0; qflip_a = 4'h0;
    en_b = 1'b0; clr_b = 1'b0; d_b = 4'h0;
    tick(); tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rst_err_pulse", 32'(err_pulse_a), 32'd0);
    chk("rst_err_count", 32'(err_cnt_a), 32'd0);
    chk("rst_sample_count", 32'(smp_cnt_a), 32'd0);
    chk("rst_fe_valid", 32'(fe_vld_a), 32'd0);
    chk("rst_fe_exp", 32'(fe_exp_a), 32'd0);
    chk("rst_fe_q", 32'(fe_q_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_b_busy", 32'(busy_b), 32'd0);
    chk("rst_b_sample_count", 32'(smp_cnt_b), 32'd0);

    // A: ideal DFF, first compare one clock after enable
    en_a = 1'b1; d_a = dv[0];
    tick();
    chk("a_enable_busy", 32'(busy_a), 32'd1);
    chk("a_enable_sample", 32'(smp_cnt_a), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      d_a = dv[i];
      tick();
      chk("a_stream_sample", 32'(smp_cnt_a), 32'(i));
      chk("a_stream_pulse", 32'(err_pulse_a), 32'd0);
    end
    chk("a_stream_err", 32'(err_cnt_a), 32'd0);

    // A: qbar forced equal to q for one cycle while q holds 3
    d_a = 4'h6; inj_a = 1'b1;
    tick();
    chk("a_inj_pulse", 32'(err_pulse_a), 32'd1);
    chk("a_inj_err", 32'(err_cnt_a), 32'd1);
    chk("a_inj_sample", 32'(smp_cnt_a), 32'd5);
    chk("a_inj_fe_valid", 32'(fe_vld_a), 32'd1);
    chk("a_inj_fe_exp", 32'(fe_exp_a), 32'h3);
    chk("a_inj_fe_q", 32'(fe_q_a), 32'h3);
    inj_a = 1'b0; d_a = 4'h7;
    tick();
    chk("a_after_pulse", 32'(err_pulse_a), 32'd0);
    chk("a_after_err", 32'(err_cnt_a), 32'd1);
    chk("a_after_sample", 32'(smp_cnt_a), 32'd6);

    // A: wrong q (7 observed as 6); first capture must be retained
    qflip_a = 4'h1; d_a = 4'h8;
    tick();
    chk("a_qerr_err", 32'(err_cnt_a), 32'd2);
    chk("a_qerr_pulse", 32'(err_pulse_a), 32'd1);
    chk("a_qerr_fe_exp_held", 32'(fe_exp_a), 32'h3);
    chk("a_qerr_fe_q_held", 32'(fe_q_a), 32'h3);

    // A: clear with en=1 -> counters zeroed, refill before comparing
    qflip_a = 4'h0; clr_a = 1'b1; d_a = 4'h9;
    tick();
    chk("a_clr_sample", 32'(smp_cnt_a), 32'd0);
    chk("a_clr_err", 32'(err_cnt_a), 32'd0);
    chk("a_clr_fe_valid", 32'(fe_vld_a), 32'd0);
    chk("a_clr_fe_exp", 32'(fe_exp_a), 32'd0);
    chk("a_clr_pulse", 32'(err_pulse_a), 32'd0);
    chk("a_clr_busy", 32'(busy_a), 32'd1);
    clr_a = 1'b0; d_a = 4'hB;
    tick();
    chk("a_refill_sample", 32'(smp_cnt_a), 32'd0);
    d_a = 4'hC;
    tick();
    chk("a_recheck_sample", 32'(smp_cnt_a), 32'd1);
    chk("a_recheck_err", 32'(err_cnt_a), 32'd0);

    // A: en=0 leaves CHECK; re-enable refills
    en_a = 1'b0;
    tick();
    chk("a_dis_busy", 32'(busy_a), 32'd0);
    chk("a_dis_sample", 32'(smp_cnt_a), 32'd1);
    en_a = 1'b1; d_a = 4'hD;
    tick();
    chk("a_reen_sample", 32'(smp_cnt_a), 32'd1);
    tick();
    chk("a_reen_compare", 32'(smp_cnt_a), 32'd2);
    chk("a_reen_err", 32'(err_cnt_a), 32'd0);
    en_a = 1'b0;

    // B: three fill clocks without counting
    en_b = 1'b1; d_b = 4'h5;
    tick();
    chk("b_fill0_busy", 32'(busy_b), 32'd1);
    chk("b_fill0_sample", 32'(smp_cnt_b), 32'd0);
    d_b = 4'hA;
    tick();
    chk("b_fill1_sample", 32'(smp_cnt_b), 32'd0);
    d_b = 4'h5;
    tick();
    chk("b_fill2_sample", 32'(smp_cnt_b), 32'd0);
    chk("b_fill2_err", 32'(err_cnt_b), 32'd0);

    // B: every compare mismatches; 4-bit counters saturate at 15
    for (int i = 0; i < 20; i++) begin
      d_b = (d_b == 4'h5) ? 4'hA : 4'h5;
      tick();
      chk("b_sat_err", 32'(err_cnt_b), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      chk("b_sat_sample", 32'(smp_cnt_b), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      chk("b_sat_pulse", 32'(err_pulse_b), 32'd1);
      if (i == 0) begin
        chk("b_fe_valid", 32'(fe_vld_b), 32'd1);
        chk("b_fe_exp", 32'(fe_exp_b), 32'h5);
        chk("b_fe_q", 32'(fe_q_b), 32'hA);
      end
    end

    // B: clear with en=1 restarts FILL
    clr_b = 1'b1;
    d_b = (d_b == 4'h5) ? 4'hA : 4'h5;
    tick();
    chk("b_clr_sample", 32'(smp_cnt_b), 32'd0);
    chk("b_clr_err", 32'(err_cnt_b), 32'd0);
    chk("b_clr_fe_valid", 32'(fe_vld_b), 32'd0);
    chk("b_clr_pulse", 32'(err_pulse_b), 32'd0);
    chk("b_clr_busy", 32'(busy_b), 32'd1);
    clr_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_b = (d_b == 4'h5) ? 4'hA : 4'h5;
      tick();
    end
    chk("b_refill_sample", 32'(smp_cnt_b), 32'd0);
    chk("b_refill_busy", 32'(busy_b), 32'd1);
    d_b = (d_b == 4'h5) ? 4'hA : 4'h5;
    tick();
    chk("b_recheck_sample", 32'(smp_cnt_b), 32'd1);
    chk("b_recheck_err", 32'(err_cnt_b), 32'd1);

    // B: reset mid-CHECK drops everything; next enable starts in FILL
    rst = 1'b1;
    tick();
    chk("b_rst_busy", 32'(busy_b), 32'd0);
    chk("b_rst_sample", 32'(smp_cnt_b), 32'd0);
    chk("b_rst_err", 32'(err_cnt_b), 32'd0);
    chk("b_rst_fe_valid", 32'(fe_vld_b), 32'd0);
    chk("b_rst_pulse", 32'(err_pulse_b), 32'd0);
    rst = 1'b0;
    tick();
    chk("b_rst_refill_busy", 32'(busy_b), 32'd1);
    chk("b_rst_refill_sample", 32'(smp_cnt_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
